// File: rtl/hyper_cmd_seq.sv
// hyper_cmd_seq: power-up gated 2-deep command FIFO issuing single-dword reqs to hyper_xface
module hyper_cmd_seq #(
  parameter int          INIT_CYCLES  = 2000,
  parameter int          BUSY_TIMEOUT = 15,
  parameter logic [7:0]  LAT_1X       = 8'h12,
  parameter logic [7:0]  LAT_2X       = 8'h16
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        init_done,
  output logic        err,
  output logic        rd_req,
  output logic        wr_req,
  output logic [31:0] addr,
  output logic [31:0] wr_d,
  output logic [3:0]  wr_byte_en,
  output logic [5:0]  rd_num_dwords,
  output logic [7:0]  latency_1x,
  output logic [7:0]  latency_2x,
  output logic        mem_or_reg,
  input  logic        busy,
  input  logic [31:0] rd_d
);
  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [68:0]   fifo_q [2];
  logic [68:0]   head;
  logic          wp_q, rp_q;
  logic [1:0]    cnt_q;
  logic          push, pop, tmo_hit, rd_done;
  logic          we_q, err_q, rsp_valid_q;
  logic [31:0]   addr_q, wr_d_q, rsp_rdata_q;
  logic [3:0]    be_q;

  assign init_done = state_q != S_INIT;
  assign cmd_ready = init_done & ~cnt_q[1];
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == S_IDLE) & (cnt_q != 2'd0) & ~busy;
  assign head      = fifo_q[rp_q];
  assign tmo_hit   = (state_q == S_WAIT_HI) & ~busy & (tmo_q == TMO_LAST);
  assign rd_done   = (state_q == S_WAIT_LO) & ~busy & ~we_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    tmo_d      = tmo_q;
    case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        state_d    = (init_cnt_q == INIT_LAST) ? S_IDLE : S_INIT;
      end
      S_IDLE:    state_d = pop ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        tmo_d   = busy ? tmo_q : tmo_q + 1'b1;
        state_d = busy ? S_WAIT_LO : (tmo_hit ? S_IDLE : S_WAIT_HI);
      end
      S_WAIT_LO: state_d = busy ? S_WAIT_LO : S_IDLE;
      default:   state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      tmo_q       <= '0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      cnt_q       <= 2'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wr_d_q      <= 32'h0;
      be_q        <= 4'h0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      tmo_q       <= tmo_d;
      wp_q        <= wp_q ^ push;
      rp_q        <= rp_q ^ pop;
      cnt_q       <= cnt_q + {1'b0, push} - {1'b0, pop};
      err_q       <= err_q | tmo_hit;
      rsp_valid_q <= rd_done;
      if (rd_done) rsp_rdata_q <= rd_d;
      if (pop) begin
        we_q   <= head[68];
        addr_q <= head[67:36];
        wr_d_q <= head[35:4];
        be_q   <= head[68] ? head[3:0] : 4'h0;
      end
    end
  end

  // Payload needs no reset: cnt_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= {cmd_we, cmd_addr, cmd_wdata, cmd_be};
  end

  assign rd_req        = (state_q == S_ISSUE) & ~we_q;
  assign wr_req        = (state_q == S_ISSUE) & we_q;
  assign addr          = addr_q;
  assign wr_d          = wr_d_q;
  assign wr_byte_en    = be_q;
  assign err           = err_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rd_num_dwords = 6'h1;
  assign latency_1x    = LAT_1X;
  assign latency_2x    = LAT_2X;
  assign mem_or_reg    = 1'b0;
endmodule

// File: tb/tb_hyper_cmd_seq.sv
// tb_hyper_cmd_seq: directed scenarios for hyper_cmd_seq with a hand-driven busy/rd_d model
module tb_hyper_cmd_seq;
  localparam int INIT = 2000;
  localparam int TMO  = 15;

  logic        clk = 1'b0;
  logic        reset_l, cmd_valid, cmd_ready, cmd_we, busy;
  logic [31:0] cmd_addr, cmd_wdata, rd_d;
  logic [3:0]  cmd_be;
  logic        rsp_valid, init_done, err, rd_req, wr_req, mem_or_reg;
  logic [31:0] rsp_rdata, addr, wr_d;
  logic [3:0]  wr_byte_en;
  logic [5:0]  rd_num_dwords;
  logic [7:0]  latency_1x, latency_2x;

  int vecs = 0, errs = 0;
  int req_n = 0, rsp_n = 0, both_n = 0;

  hyper_cmd_seq dut (
    .clk(clk), .reset_l(reset_l), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done), .err(err),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wr_d(wr_d), .wr_byte_en(wr_byte_en),
    .rd_num_dwords(rd_num_dwords), .latency_1x(latency_1x), .latency_2x(latency_2x),
    .mem_or_reg(mem_or_reg), .busy(busy), .rd_d(rd_d)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_req | wr_req) req_n <= req_n + 1;
    if (rd_req & wr_req) both_n <= both_n + 1;
    if (rsp_valid) rsp_n <= rsp_n + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    vecs++;
    if (cmd_ready !== 1'b1) begin errs++; $display("FAIL push_ready: got %b want 1", cmd_ready); end
    cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_be = be; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req;
    int n = 0;
    while (!(rd_req | wr_req) && n < 40) begin tick; n++; end
    vecs++;
    if (!(rd_req | wr_req)) begin errs++; $display("FAIL req_timeout: got no req within %0d cycles", n); end
  endtask

  task automatic wait_init;
    int bad = 0;
    for (int i = 1; i <= INIT; i++) begin
      tick;
      if (i < INIT && (init_done | cmd_ready | rd_req | wr_req)) bad++;
    end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL init_quiet: got %0d active cycles want 0", bad); end
    vecs++;
    if (init_done !== 1'b1 || cmd_ready !== 1'b1) begin
      errs++; $display("FAIL init_done: got done=%b ready=%b want 1 1", init_done, cmd_ready);
    end
  endtask

  task automatic do_cmd(input logic we, input logic [31:0] a, input logic [31:0] d);
    wait_req;
    vecs++;
    if (wr_req !== we || rd_req !== !we || addr !== a) begin
      errs++; $display("FAIL cmd_issue: got wr=%b rd=%b addr=%h want wr=%b addr=%h", wr_req, rd_req, addr, we, a);
    end
    if (we) begin
      vecs++;
      if (wr_d !== d) begin errs++; $display("FAIL cmd_wdata: got %h want %h", wr_d, d); end
    end
    tick; busy = 1'b1; tick; tick;
    busy = 1'b0; rd_d = d;
    tick;
    vecs++;
    if (rsp_valid !== !we || (!we && rsp_rdata !== d)) begin
      errs++; $display("FAIL cmd_rsp: got v=%b d=%h want v=%b d=%h", rsp_valid, rsp_rdata, !we, d);
    end
  endtask

  task automatic test_reset;
    reset_l = 1'b0; busy = 1'b0; rd_d = 32'h0; cmd_valid = 1'b0;
    cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_be = 4'h0;
    repeat (3) tick;
    vecs++;
    if ({init_done, cmd_ready, rd_req, wr_req, rsp_valid, err} !== 6'b0) begin
      errs++; $display("FAIL rst_ctrl: got %b want 000000", {init_done, cmd_ready, rd_req, wr_req, rsp_valid, err});
    end
    vecs++;
    if (addr !== 32'h0 || wr_d !== 32'h0 || wr_byte_en !== 4'h0 || rsp_rdata !== 32'h0) begin
      errs++; $display("FAIL rst_data: got a=%h d=%h be=%h r=%h want 0", addr, wr_d, wr_byte_en, rsp_rdata);
    end
    vecs++;
    if (rd_num_dwords !== 6'h1 || latency_1x !== 8'h12 || latency_2x !== 8'h16 || mem_or_reg !== 1'b0) begin
      errs++; $display("FAIL consts: got n=%h l1=%h l2=%h m=%b want 01 12 16 0", rd_num_dwords, latency_1x, latency_2x, mem_or_reg);
    end
    reset_l = 1'b1;
    wait_init;
    vecs++;
    if (req_n != 0) begin errs++; $display("FAIL init_noreq: got %0d reqs want 0", req_n); end
  endtask

  task automatic test_write;
    int bad = 0, r0;
    push(1'b1, 32'h012345, 32'h012345, 4'hF);
    wait_req;
    vecs++;
    if (wr_req !== 1'b1 || rd_req !== 1'b0) begin errs++; $display("FAIL wr_kind: got wr=%b rd=%b want 1 0", wr_req, rd_req); end
    vecs++;
    if (addr !== 32'h012345 || wr_d !== 32'h012345 || wr_byte_en !== 4'hF) begin
      errs++; $display("FAIL wr_fields: got a=%h d=%h be=%h want 00012345 00012345 f", addr, wr_d, wr_byte_en);
    end
    tick; busy = 1'b1;
    vecs++;
    if ((wr_req | rd_req) !== 1'b0) begin errs++; $display("FAIL wr_pulse: got req high for 2 cycles want 1"); end
    repeat (4) begin
      tick;
      if (addr !== 32'h012345 || wr_d !== 32'h012345 || wr_byte_en !== 4'hF || (rd_req | wr_req)) bad++;
    end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL wr_stable: got %0d unstable cycles want 0", bad); end
    r0 = rsp_n;
    busy = 1'b0;
    tick; tick;
    vecs++;
    if (rsp_n != r0 || wr_byte_en !== 4'hF) begin errs++; $display("FAIL wr_norsp: got rsp=%0d be=%h want 0 f", rsp_n - r0, wr_byte_en); end
  endtask

  task automatic test_read;
    int r0;
    push(1'b0, 32'h6789ab, 32'h11111111, 4'hF);
    wait_req;
    vecs++;
    if (rd_req !== 1'b1 || wr_req !== 1'b0 || addr !== 32'h6789ab || wr_byte_en !== 4'h0) begin
      errs++; $display("FAIL rd_issue: got rd=%b wr=%b a=%h be=%h want 1 0 006789ab 0", rd_req, wr_req, addr, wr_byte_en);
    end
    tick; busy = 1'b1; tick; tick;
    r0 = rsp_n;
    busy = 1'b0; rd_d = 32'hDEADBEEF;
    vecs++;
    if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rd_early: got rsp_valid=%b want 0", rsp_valid); end
    tick;
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      errs++; $display("FAIL rd_rsp: got v=%b d=%h want 1 deadbeef", rsp_valid, rsp_rdata);
    end
    rd_d = 32'h0;
    tick;
    vecs++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF || rsp_n != r0 + 1) begin
      errs++; $display("FAIL rd_hold: got v=%b d=%h n=%0d want 0 deadbeef 1", rsp_valid, rsp_rdata, rsp_n - r0);
    end
  endtask

  task automatic test_back_to_back;
    int r0 = req_n;
    busy = 1'b1;
    push(1'b1, 32'h0000_1000, 32'h1111_0001, 4'hF);
    push(1'b0, 32'h0000_2000, 32'h0, 4'hF);
    vecs++;
    if (cmd_ready !== 1'b0) begin errs++; $display("FAIL b2b_full: got ready=%b want 0", cmd_ready); end
    cmd_we = 1'b1; cmd_addr = 32'h0000_3000; cmd_wdata = 32'h3333_0003; cmd_be = 4'h5; cmd_valid = 1'b1;
    tick;
    vecs++;
    if (req_n != r0 || cmd_ready !== 1'b0) begin errs++; $display("FAIL b2b_hold: got reqs=%0d ready=%b want 0 0", req_n - r0, cmd_ready); end
    busy = 1'b0;
    tick;
    vecs++;
    if (wr_req !== 1'b1 || addr !== 32'h0000_1000 || wr_d !== 32'h1111_0001 || cmd_ready !== 1'b1) begin
      errs++; $display("FAIL b2b_first: got wr=%b a=%h d=%h ready=%b want 1 00001000 11110001 1", wr_req, addr, wr_d, cmd_ready);
    end
    tick;
    cmd_valid = 1'b0;
    vecs++;
    if (cmd_ready !== 1'b0) begin errs++; $display("FAIL b2b_refill: got ready=%b want 0", cmd_ready); end
    busy = 1'b1; tick; tick;
    busy = 1'b0; tick;
    do_cmd(1'b0, 32'h0000_2000, 32'hA5A5_0002);
    do_cmd(1'b1, 32'h0000_3000, 32'h3333_0003);
    vecs++;
    if (wr_byte_en !== 4'h5 || req_n != r0 + 3) begin errs++; $display("FAIL b2b_count: got be=%h reqs=%0d want 5 3", wr_byte_en, req_n - r0); end
  endtask

  task automatic test_timeout;
    int r0 = rsp_n;
    logic e15 = 1'b0, e16 = 1'b0;
    busy = 1'b0;
    push(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    push(1'b1, 32'h0000_0200, 32'hCAFEF00D, 4'h3);
    wait_req;
    vecs++;
    if (rd_req !== 1'b1 || addr !== 32'h0000_0100) begin errs++; $display("FAIL to_issue: got rd=%b a=%h want 1 00000100", rd_req, addr); end
    for (int i = 1; i <= TMO + 1; i++) begin
      tick;
      if (i == TMO) e15 = err;
      if (i == TMO + 1) e16 = err;
    end
    vecs++;
    if (e15 !== 1'b0 || e16 !== 1'b1) begin errs++; $display("FAIL to_err: got err@15=%b err@16=%b want 0 1", e15, e16); end
    vecs++;
    if (rsp_n != r0) begin errs++; $display("FAIL to_norsp: got %0d rsp want 0", rsp_n - r0); end
    tick;
    vecs++;
    if (wr_req !== 1'b1 || addr !== 32'h0000_0200 || wr_d !== 32'hCAFEF00D || wr_byte_en !== 4'h3) begin
      errs++; $display("FAIL to_next: got wr=%b a=%h d=%h be=%h want 1 00000200 cafef00d 3", wr_req, addr, wr_d, wr_byte_en);
    end
    tick; busy = 1'b1; tick; tick;
    busy = 1'b0; tick;
    vecs++;
    if (err !== 1'b1) begin errs++; $display("FAIL to_sticky: got err=%b want 1", err); end
  endtask

  task automatic test_reset_mid;
    int r0, s0;
    push(1'b0, 32'h0000_0300, 32'h0, 4'hF);
    wait_req;
    tick; busy = 1'b1; tick;
    push(1'b1, 32'h0000_0400, 32'h4444_4444, 4'hF);
    #3 reset_l = 1'b0;
    #1;
    vecs++;
    if ({init_done, cmd_ready, rd_req, wr_req, rsp_valid, err} !== 6'b0) begin
      errs++; $display("FAIL mid_ctrl: got %b want 000000", {init_done, cmd_ready, rd_req, wr_req, rsp_valid, err});
    end
    vecs++;
    if (addr !== 32'h0 || wr_d !== 32'h0 || wr_byte_en !== 4'h0 || rsp_rdata !== 32'h0) begin
      errs++; $display("FAIL mid_data: got a=%h d=%h be=%h r=%h want 0", addr, wr_d, wr_byte_en, rsp_rdata);
    end
    busy = 1'b0; rd_d = 32'h1234_5678;
    tick; tick;
    r0 = req_n; s0 = rsp_n;
    reset_l = 1'b1;
    wait_init;
    repeat (10) tick;
    vecs++;
    if (req_n != r0 || rsp_n != s0) begin errs++; $display("FAIL mid_stale: got reqs=%0d rsps=%0d want 0 0", req_n - r0, rsp_n - s0); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    vecs++;
    if (both_n != 0) begin errs++; $display("FAIL req_overlap: got %0d cycles with rd_req&wr_req want 0", both_n); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
